// File: rtl/sram_ctrl.sv
// Valid/ready front end for a single-port synchronous SRAM: absorbs the one-cycle
// read latency, does read-modify-write for byte-masked writes, one in-order response per request.
module sram_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wstrb,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic            rsp_we,
  output logic [DW-1:0]   rsp_rdata,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  output logic            sram_wen,
  input  logic [DW-1:0]   sram_rdata
);

  localparam int SW = DW / 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_CAP = 2'd1;
  localparam logic [1:0] RMW_WR = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;

  logic          accept;
  logic          strb_full;
  logic          strb_zero;
  logic          rsp_load;
  logic          rsp_load_we;
  logic [DW-1:0] rsp_load_data;

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] new_data,
                                               input logic [DW-1:0] old_data,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_data;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

  assign req_rdy   = rst_n && (state == IDLE) && (!rsp_vld || rsp_rdy);
  assign accept    = req_vld && req_rdy;
  assign strb_full = &req_wstrb;
  assign strb_zero = ~|req_wstrb;

  // SRAM port: request passes straight through on accept, otherwise the held copies drive it
  always_comb begin
    sram_addr  = addr_q;
    sram_wdata = wdata_q;
    sram_wen   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sram_addr  = req_addr;
          sram_wdata = req_wdata;
          sram_wen   = req_we && strb_full;
        end
      end
      RMW_WR: begin
        sram_wdata = byte_merge(wdata_q, sram_rdata, wstrb_q);
        sram_wen   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rsp_load      = 1'b0;
    rsp_load_we   = 1'b1;
    rsp_load_data = '0;
    case (state)
      IDLE:   rsp_load = accept && req_we && (strb_full || strb_zero);
      RD_CAP: begin
        rsp_load      = 1'b1;
        rsp_load_we   = 1'b0;
        rsp_load_data = sram_rdata;
      end
      RMW_WR: rsp_load = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_vld   <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (!req_we)                       state <= RD_CAP;
            else if (!strb_full && !strb_zero) state <= RMW_WR;
          end
        end
        RD_CAP:  state <= IDLE;
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase

      // a new response overrides a drain happening in the same cycle
      if (rsp_load) begin
        rsp_vld   <= 1'b1;
        rsp_we    <= rsp_load_we;
        rsp_rdata <= rsp_load_data;
      end else if (rsp_vld && rsp_rdy) begin
        rsp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM, word-level reference memory and
// per-request expectations for latency, response contents and write pulses.
module tb_sram_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_vld;
  logic          req_rdy;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_wen;
  logic [DW-1:0] sram_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int wen_cnt = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  sram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wen(sram_wen),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // single-port synchronous SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    else          sram_rdata     <= mem[sram_addr];
  end

  always @(posedge clk) if (sram_wen) wen_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic void ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  // one complete request/response with rsp_rdy held high
  task automatic single(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input string tag);
    int n;
    int wen0;
    int exp_lat;
    int exp_wen;
    logic [DW-1:0] exp_data;
    rsp_rdy = 1'b1; req_vld = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    n = 0;
    #1;
    while (!req_rdy && n < 20) begin @(negedge clk); #1; n++; end
    n_cmp++;
    if (n >= 20) begin
      $display("FAIL %s accept: req_rdy stayed 0, required 1 within 20 cycles", tag);
      n_err++;
    end
    wen0     = wen_cnt;
    exp_lat  = (we && (s == 4'hF || s == 4'h0)) ? 1 : 2;
    exp_wen  = (we && s != 4'h0) ? 1 : 0;
    exp_data = we ? '0 : ref_mem[a];
    if (we) ref_write(a, d, s);
    @(negedge clk);
    req_vld = 1'b0;
    n = 1;
    while (!rsp_vld && n < 10) begin @(negedge clk); n++; end
    n_cmp++;
    if (n != exp_lat) begin
      $display("FAIL %s latency: got %0d cycles, required %0d", tag, n, exp_lat);
      n_err++;
    end
    n_cmp++;
    if (rsp_we !== we || rsp_rdata !== exp_data) begin
      $display("FAIL %s response: we=%b data=%h, required we=%b data=%h",
               tag, rsp_we, rsp_rdata, we, exp_data);
      n_err++;
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b0 || (wen_cnt - wen0) != exp_wen) begin
      $display("FAIL %s drain: rsp_vld=%b wen_pulses=%0d, required 0 and %0d",
               tag, rsp_vld, wen_cnt - wen0, exp_wen);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_vld = 1'b1; req_we = 1'b1; req_addr = 10'h001; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
    ref_write(10'h001, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    n_cmp++;
    if (rsp_vld !== 1'b1) begin
      $display("FAIL reset_pre rsp_vld: got %b, required 1", rsp_vld); n_err++;
    end
    req_addr = 10'h3A5; req_wdata = $urandom;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({req_rdy, rsp_vld, rsp_we, sram_wen} !== 4'b0 || rsp_rdata !== '0 ||
          sram_addr !== '0 || sram_wdata !== '0) begin
        $display("FAIL reset_outputs: rdy=%b vld=%b we=%b wen=%b rdata=%h addr=%h wdata=%h, required all 0",
                 req_rdy, rsp_vld, rsp_we, sram_wen, rsp_rdata, sram_addr, sram_wdata);
        n_err++;
      end
      @(negedge clk); #1;
    end
    req_vld = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_rdy !== 1'b1 || rsp_vld !== 1'b0) begin
      $display("FAIL reset_release: req_rdy=%b rsp_vld=%b, required 1 and 0", req_rdy, rsp_vld);
      n_err++;
    end
  endtask

  task automatic test_full_write_read();
    single(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, "full_write");
    single(1'b0, 10'h005, '0, 4'h0, "full_read");
  endtask

  task automatic test_partial();
    single(1'b1, 10'h005, 32'h11223344, 4'hF, "partial_init");
    single(1'b1, 10'h005, 32'hAABBCCDD, 4'b0101, "partial_write");
    single(1'b0, 10'h005, '0, 4'h0, "partial_read");
    single(1'b1, 10'h006, 32'h55555555, 4'h0, "zero_strobe_write");
    single(1'b0, 10'h006, '0, 4'h0, "zero_strobe_read");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_data;
    int wen0;
    single(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, "bp_init");
    exp_data = ref_mem[5];
    rsp_rdy = 1'b0; req_vld = 1'b1; req_we = 1'b0; req_addr = 10'h005; req_wstrb = 4'h0;
    #1;
    n_cmp++;
    if (req_rdy !== 1'b1) begin
      $display("FAIL bp_accept: req_rdy=%b, required 1", req_rdy); n_err++;
    end
    @(negedge clk);
    req_we = 1'b1; req_addr = 10'h009; req_wdata = $urandom; req_wstrb = 4'hF;
    wen0 = wen_cnt;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_vld !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== exp_data || req_rdy !== 1'b0) begin
        $display("FAIL bp_hold[%0d]: vld=%b we=%b data=%h rdy=%b, required 1 0 %h 0",
                 i, rsp_vld, rsp_we, rsp_rdata, req_rdy, exp_data);
        n_err++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (wen_cnt != wen0) begin
      $display("FAIL bp_no_accept: %0d writes during stall, required 0", wen_cnt - wen0); n_err++;
    end
    rsp_rdy = 1'b1;
    #1;
    n_cmp++;
    if (req_rdy !== 1'b1) begin
      $display("FAIL bp_release_rdy: req_rdy=%b, required 1", req_rdy); n_err++;
    end
    ref_write(10'h009, req_wdata, 4'hF);
    @(negedge clk);
    req_vld = 1'b0;
    n_cmp++;
    if (rsp_vld !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== '0) begin
      $display("FAIL bp_next_rsp: vld=%b we=%b data=%h, required 1 1 0", rsp_vld, rsp_we, rsp_rdata);
      n_err++;
    end
    @(negedge clk);
    single(1'b0, 10'h009, '0, 4'h0, "bp_readback");
  endtask

  task automatic test_back_to_back();
    int wen0;
    rsp_rdy = 1'b1;
    wen0 = wen_cnt;
    for (int k = 0; k < 8; k++) begin
      req_vld = 1'b1; req_we = 1'b1; req_addr = AW'(k); req_wdata = $urandom; req_wstrb = 4'hF;
      ref_write(AW'(k), req_wdata, 4'hF);
      #1;
      n_cmp++;
      if (req_rdy !== 1'b1 || (k > 0 && (rsp_vld !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== '0))) begin
        $display("FAIL stream[%0d]: rdy=%b vld=%b we=%b data=%h, required 1 1 1 0",
                 k, req_rdy, rsp_vld, rsp_we, rsp_rdata);
        n_err++;
      end
      @(negedge clk);
    end
    req_vld = 1'b0;
    n_cmp++;
    if (rsp_vld !== 1'b1 || (wen_cnt - wen0) != 8) begin
      $display("FAIL stream_end: rsp_vld=%b writes=%0d, required 1 and 8", rsp_vld, wen_cnt - wen0);
      n_err++;
    end
    @(negedge clk);
    for (int k = 0; k < 8; k++) single(1'b0, AW'(k), '0, 4'h0, "stream_readback");
  endtask

  task automatic test_random();
    logic [3:0] s;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       s = 4'hF;
        1:       s = 4'h0;
        default: s = 4'($urandom);
      endcase
      single(1'($urandom), AW'($urandom_range(0, 15)), $urandom, s, "random");
    end
  endtask

  task automatic test_rmw_reset();
    single(1'b1, 10'h003, $urandom, 4'hF, "rmw_reset_init");
    rsp_rdy = 1'b1; req_vld = 1'b1; req_we = 1'b1; req_addr = 10'h003;
    req_wdata = ~ref_mem[3]; req_wstrb = 4'b0011;
    @(negedge clk);
    req_vld = 1'b0;
    #1;
    n_cmp++;
    if (sram_wen !== 1'b1) begin
      $display("FAIL rmw_wen_before: sram_wen=%b, required 1", sram_wen); n_err++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sram_wen !== 1'b0 || rsp_vld !== 1'b0 || req_rdy !== 1'b0) begin
      $display("FAIL rmw_reset: wen=%b vld=%b rdy=%b, required 0 0 0", sram_wen, rsp_vld, req_rdy);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_vld !== 1'b0) begin
        $display("FAIL rmw_no_rsp[%0d]: rsp_vld=%b, required 0", i, rsp_vld); n_err++;
      end
    end
    single(1'b0, 10'h003, '0, 4'h0, "rmw_reset_readback");
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_full_write_read();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_rmw_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
